// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit that owns the HI/LO registers.
//
// Executes MULT, MULTU, DIV and DIVU in a fixed 33-cycle sequence:
// one launch edge, 32 CALC edges and one FIX edge. When idle, it also
// services MTHI/MTLO writes.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous, active-low; clears all state
//   start  in   1  launch the operation selected by op (sampled only in IDLE)
//   op     in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a  in  32  multiplicand / dividend; MTHI/MTLO write data
//   src_b  in  32  multiplier / divisor
//   hi_we  in   1  MTHI: hi <= src_a (IDLE only)
//   lo_we  in   1  MTLO: lo <= src_a (IDLE only)
//   busy   out  1  operation in flight
//   done   out  1  one-cycle pulse when an operation updates HI/LO
//   hi     out 32  HI register
//   lo     out 32  LO register
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        sign_a_q;
  logic        sign_b_q;
  // Holds the multiplicand for multiplies and the divisor for divides.
  logic [31:0] operand_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {remainder, dividend bits shifting out / quotient shifting in}.
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // Launch-time operand conditioning. Only signed ops take absolute values.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // One iteration of each algorithm.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [64:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  // Sign-corrected final results.
  logic [63:0] prod_res;
  logic [31:0] quot_res;
  logic [31:0] rem_res;

  always_comb begin
    a_neg = ~op[0] & src_a[31];
    b_neg = ~op[0] & src_b[31];
    abs_a = a_neg ? (32'd0 - src_a) : src_a;
    abs_b = b_neg ? (32'd0 - src_b) : src_b;

    // Radix-2 shift-add: add the multiplicand when the multiplier LSB is set,
    // then shift the whole 65-bit result right by one.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor whenever it fits. The difference always fits in 32
    // bits because the remainder stays below the divisor.
    div_shift = {acc_q, 1'b0};
    div_ge    = div_shift[64:32] >= {1'b0, operand_q};
    div_diff  = div_shift[63:32] - operand_q;
    div_next  = {(div_ge ? div_diff : div_shift[63:32]), acc_q[30:0], div_ge};

    prod_res = (op_q == 2'b00 && (sign_a_q ^ sign_b_q)) ? (64'd0 - acc_q) : acc_q;
    quot_res = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    // Remainder follows the dividend sign. With a zero divisor, the remainder
    // equals |dividend|, so this restores the original src_a.
    rem_res  = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 2'b00;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      operand_q <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // start wins over a simultaneous MTHI/MTLO.
            state_q  <= StCalc;
            cnt_q    <= 5'd31;
            op_q     <= op;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            busy_q   <= 1'b1;
            if (op[1]) begin
              operand_q <= abs_b;
              acc_q     <= {32'd0, abs_a};
            end else begin
              operand_q <= abs_a;
              acc_q     <= {32'd0, abs_b};
            end
          end else begin
            if (hi_we) hi_q <= src_a;
            if (lo_we) lo_q <= src_a;
          end
        end
        StCalc: begin
          acc_q <= op_q[1] ? div_next : mul_next;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_q <= StFix;
        end
        StFix: begin
          if (op_q[1]) begin
            hi_q <= rem_res;
            lo_q <= (operand_q == 32'd0) ? 32'hFFFF_FFFF : quot_res;
          end else begin
            hi_q <= prod_res[63:32];
            lo_q <= prod_res[31:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchecks = 0;
  int nerr    = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: MIPS semantics from plain 64-bit arithmetic. Returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    longint      sq;
    longint      sr;
    logic [63:0] r;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return r;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launches one operation at the current negedge and checks it end to end.
  // noisy: assert MTHI/MTLO alongside start, then fire start/MTHI/MTLO mid-CALC.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit noisy);
    logic [63:0] exp;
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;
    int          cycles;
    bit          held;
    exp     = model(o, a, b);
    hi_prev = hi;
    lo_prev = lo;
    op      = o;
    src_a   = a;
    src_b   = b;
    start   = 1'b1;
    hi_we   = noisy;
    lo_we   = noisy;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    check32({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    check32({tag, "_done_low"}, {31'd0, done}, 32'd0);
    cycles = 0;
    held   = 1'b1;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (hi !== hi_prev || lo !== lo_prev) held = 1'b0;
      if (noisy && cycles == 10) begin
        start = 1'b1;
        op    = ~o;
        hi_we = 1'b1;
        lo_we = 1'b1;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'd3;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(negedge clk);
    end
    check32({tag, "_busy_cycles"}, cycles, 33);
    check32({tag, "_hilo_held"}, {31'd0, held}, 32'd1);
    check32({tag, "_done"}, {31'd0, done}, 32'd1);
    check32({tag, "_hi"}, hi, exp[63:32]);
    check32({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'd0;
    src_b = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed operations; successive calls start in the done cycle (back-to-back).
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0, 1'b0);
    run_op("div_negzero", 2'b10, 32'hFFFF_0000, 32'd0, 1'b0);
    check32("done_pulse_one", {31'd0, done}, 32'd1);
    @(negedge clk);
    check32("done_fall", {31'd0, done}, 32'd0);

    // MTHI then MTLO while idle.
    hi_we = 1'b1;
    src_a = 32'hAAAA_0000;
    @(negedge clk);
    hi_we = 1'b0;
    check32("mthi", hi, 32'hAAAA_0000);
    lo_we = 1'b1;
    src_a = 32'h0000_5555;
    @(negedge clk);
    lo_we = 1'b0;
    check32("mtlo", lo, 32'h0000_5555);
    check32("mtlo_hi_kept", hi, 32'hAAAA_0000);
    hi_we = 1'b1;
    lo_we = 1'b1;
    src_a = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check32("mthilo_hi", hi, 32'h1357_9BDF);
    check32("mthilo_lo", lo, 32'h1357_9BDF);

    // Writes and a second start during CALC must be ignored.
    run_op("noisy_mult", 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    run_op("noisy_div", 2'b10, 32'h8765_4321, 32'h0000_0123, 1'b1);

    // Asynchronous reset in the middle of a MULT.
    op    = 2'b00;
    src_a = 32'h7FFF_FFFF;
    src_b = 32'h0000_0005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_done", {31'd0, done}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("post_reset", 2'b00, 32'h7FFF_FFFF, 32'h0000_0005, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (($urandom_range(0, 3)) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($signed(6'($urandom)));
        2:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
